// File: rtl/cpu_run_controller.sv
// Run controller: sequences CPU reset, bounds the run by cycle budget, reports halt/stall/timeout verdict.
// Latency: all outputs registered, verdict one cycle after the terminating RUN cycle; no backpressure (strobes always accepted).
module cpu_run_controller #(
  parameter int CNT_W         = 32,
  parameter int RST_CYCLES    = 1,
  parameter int MAX_CYCLES    = 200,
  parameter int STALL_LIMIT   = 64,
  parameter int EXPECT_RETIRE = 17,
  parameter int HALT_MODE     = 1,
  parameter int AUTO_START    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             retire,
  input  logic             halt,
  output logic             cpu_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int              RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]   RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] STALL_C = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXPECT_RETIRE);

  localparam logic [1:0] FC_OK     = 2'd0;
  localparam logic [1:0] FC_RETIRE = 2'd1;
  localparam logic [1:0] FC_STALL  = 2'd2;
  localparam logic [1:0] FC_TMO    = 2'd3;

  state_t           state, state_n;
  logic [RW-1:0]    rst_cnt, rst_cnt_n;
  logic [CNT_W-1:0] stall_cnt, stall_n;
  logic [CNT_W-1:0] cycle_n, retire_n;
  logic             pass_n;
  logic [1:0]       code_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    cycle_n   = cycle_cnt;
    retire_n  = retire_cnt;
    stall_n   = stall_cnt;
    pass_n    = pass;
    code_n    = fail_code;

    unique case (state)
      IDLE: begin
        if ((AUTO_START != 0) || start) state_n = RESET;
      end
      RESET: begin
        if (rst_cnt == RST_LAST) state_n = RUN;
        else rst_cnt_n = rst_cnt + 1'b1;
      end
      RUN: begin
        cycle_n  = sat_inc(cycle_cnt);
        retire_n = retire ? sat_inc(retire_cnt) : retire_cnt;
        stall_n  = retire ? '0 : sat_inc(stall_cnt);
        // Termination looks at the counts including this cycle's update.
        if ((HALT_MODE != 0) && halt) begin
          state_n = DONE;
          if ((EXPECT_RETIRE == 0) || (retire_n == EXP_C)) begin
            pass_n = 1'b1;
            code_n = FC_OK;
          end else begin
            pass_n = 1'b0;
            code_n = FC_RETIRE;
          end
        end else if ((STALL_LIMIT != 0) && (stall_n == STALL_C)) begin
          state_n = DONE;
          pass_n  = 1'b0;
          code_n  = FC_STALL;
        end else if (cycle_n == MAX_C) begin
          state_n = DONE;
          pass_n  = 1'b0;
          code_n  = FC_TMO;
        end
      end
      DONE: begin
        if (start) state_n = RESET;
      end
    endcase

    if ((state_n == RESET) && (state != RESET)) begin
      rst_cnt_n = '0;
      cycle_n   = '0;
      retire_n  = '0;
      stall_n   = '0;
      pass_n    = 1'b0;
      code_n    = FC_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      stall_cnt  <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      pass       <= 1'b0;
      fail_code  <= FC_OK;
      cpu_rst    <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      rst_cnt    <= rst_cnt_n;
      stall_cnt  <= stall_n;
      cycle_cnt  <= cycle_n;
      retire_cnt <= retire_n;
      pass       <= pass_n;
      fail_code  <= code_n;
      cpu_rst    <= (state_n != RUN);
      running    <= (state_n == RUN);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: instance 0 uses defaults, instance 1 has a 4-cycle reset,
// manual start and stall detection disabled. Verdicts are scored when done rises.
module tb_cpu_run_controller;

  logic        clk;
  logic [1:0]  rst_v, start_v, retire_v, halt_v;
  logic [1:0]  cpu_rst_v, running_v, done_v, pass_v;
  logic [1:0]  code_v [2];
  logic [31:0] cyc_v  [2];
  logic [31:0] ret_v  [2];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        pass;
    logic [1:0]  code;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  cpu_run_controller u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .retire(retire_v[0]), .halt(halt_v[0]),
    .cpu_rst(cpu_rst_v[0]), .running(running_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail_code(code_v[0]), .cycle_cnt(cyc_v[0]), .retire_cnt(ret_v[0])
  );

  cpu_run_controller #(
    .RST_CYCLES(4), .AUTO_START(0), .STALL_LIMIT(0)
  ) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .retire(retire_v[1]), .halt(halt_v[1]),
    .cpu_rst(cpu_rst_v[1]), .running(running_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail_code(code_v[1]), .cycle_cnt(cyc_v[1]), .retire_cnt(ret_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_verdict(input int k, input logic p, input logic [1:0] c,
                                input int cyc, input int ret);
    exp_t e;
    e.pass = p;
    e.code = c;
    e.cyc  = cyc;
    e.ret  = ret;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Scoreboard monitor: one verdict popped per rising edge of done.
  initial begin
    logic [1:0] prev;
    exp_t       e;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (done_v[k] === 1'b1 && prev[k] === 1'b0) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done inst%0d: got done=1, expected no verdict", k);
          end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("pass inst%0d", k), {31'd0, pass_v[k]}, {31'd0, e.pass});
            chk($sformatf("fail_code inst%0d", k), {30'd0, code_v[k]}, {30'd0, e.code});
            chk($sformatf("cycle_cnt inst%0d", k), cyc_v[k], e.cyc);
            chk($sformatf("retire_cnt inst%0d", k), ret_v[k], e.ret);
            chk($sformatf("cpu_rst_in_done inst%0d", k), {31'd0, cpu_rst_v[k]}, 32'd1);
            chk($sformatf("running_in_done inst%0d", k), {31'd0, running_v[k]}, 32'd0);
          end
        end
        prev[k] = done_v[k];
      end
    end
  end

  task automatic wait_running(input int k);
    for (int i = 0; i < 20 && running_v[k] !== 1'b1; i++) @(negedge clk);
    if (running_v[k] !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_running inst%0d: got running=0, expected 1 within 20 cycles", k);
    end
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 8 && done_v[k] !== 1'b1; i++) @(negedge clk);
    if (done_v[k] !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_done inst%0d: got done=0, expected 1 within 8 cycles", k);
    end
  endtask

  // Drives RUN cycles 1..n starting at the negedge where running was first seen.
  task automatic run_cycles(input int k, input int n, input int per, input int rmax, input int halt_at);
    for (int i = 1; i <= n; i++) begin
      retire_v[k] = (per > 0) && (i % per == 0) && (i <= rmax);
      halt_v[k]   = (i == halt_at);
      @(negedge clk);
    end
    retire_v[k] = 1'b0;
    halt_v[k]   = 1'b0;
  endtask

  task automatic restart(input int k);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    chk($sformatf("restart_done inst%0d", k), {31'd0, done_v[k]}, 32'd0);
    chk($sformatf("restart_cycle inst%0d", k), cyc_v[k], 32'd0);
    chk($sformatf("restart_retire inst%0d", k), ret_v[k], 32'd0);
    chk($sformatf("restart_pass inst%0d", k), {31'd0, pass_v[k]}, 32'd0);
    chk($sformatf("restart_cpu_rst inst%0d", k), {31'd0, cpu_rst_v[k]}, 32'd1);
    wait_running(k);
  endtask

  initial begin
    rst_v    = 2'b11;
    start_v  = 2'b00;
    retire_v = 2'b00;
    halt_v   = 2'b00;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_cpu_rst inst%0d", k), {31'd0, cpu_rst_v[k]}, 32'd1);
      chk($sformatf("rst_running inst%0d", k), {31'd0, running_v[k]}, 32'd0);
      chk($sformatf("rst_done inst%0d", k), {31'd0, done_v[k]}, 32'd0);
      chk($sformatf("rst_pass inst%0d", k), {31'd0, pass_v[k]}, 32'd0);
      chk($sformatf("rst_code inst%0d", k), {30'd0, code_v[k]}, 32'd0);
      chk($sformatf("rst_cycle inst%0d", k), cyc_v[k], 32'd0);
      chk($sformatf("rst_retire inst%0d", k), ret_v[k], 32'd0);
    end
    rst_v = 2'b00;

    // 17 retires every 3 cycles, halt together with the 17th at cycle 51.
    expect_verdict(0, 1'b1, 2'd0, 51, 17);
    wait_running(0);
    run_cycles(0, 51, 3, 51, 51);
    wait_done(0);

    // Halt after only 16 retires.
    expect_verdict(0, 1'b0, 2'd1, 50, 16);
    restart(0);
    run_cycles(0, 50, 3, 48, 50);
    wait_done(0);

    // Silent CPU: stall after 64 cycles.
    expect_verdict(0, 1'b0, 2'd2, 64, 0);
    restart(0);
    run_cycles(0, 64, 0, 0, 0);
    wait_done(0);

    // Halt coincides with the timeout cycle: halt wins.
    expect_verdict(0, 1'b0, 2'd1, 200, 66);
    restart(0);
    run_cycles(0, 200, 3, 200, 200);
    wait_done(0);

    // Reset in the middle of a run.
    restart(0);
    run_cycles(0, 10, 2, 4, 0);
    chk("midrun_cycle", cyc_v[0], 32'd10);
    chk("midrun_retire", ret_v[0], 32'd2);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("midrst_running", {31'd0, running_v[0]}, 32'd0);
    chk("midrst_cpu_rst", {31'd0, cpu_rst_v[0]}, 32'd1);
    chk("midrst_cycle", cyc_v[0], 32'd0);
    chk("midrst_retire", ret_v[0], 32'd0);
    rst_v[0] = 1'b0;
    expect_verdict(0, 1'b0, 2'd2, 64, 0);
    wait_running(0);
    run_cycles(0, 64, 0, 0, 0);
    wait_done(0);

    // DONE holds: no auto restart, retire/halt ignored.
    retire_v[0] = 1'b1;
    halt_v[0]   = 1'b1;
    repeat (4) @(negedge clk);
    retire_v[0] = 1'b0;
    halt_v[0]   = 1'b0;
    chk("done_hold", {31'd0, done_v[0]}, 32'd1);
    chk("done_hold_retire", ret_v[0], 32'd0);
    chk("done_hold_code", {30'd0, code_v[0]}, 32'd2);

    // Manual start: instance 1 has idled since reset.
    chk("idle_cpu_rst", {31'd0, cpu_rst_v[1]}, 32'd1);
    chk("idle_running", {31'd0, running_v[1]}, 32'd0);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_hold_%0d", i), {31'd0, cpu_rst_v[1]}, 32'd1);
      @(negedge clk);
    end
    chk("rst_release", {31'd0, cpu_rst_v[1]}, 32'd0);
    chk("run_after_rst", {31'd0, running_v[1]}, 32'd1);

    // Stall disabled: retire every 3 or nothing at all both end in timeout.
    expect_verdict(1, 1'b0, 2'd3, 200, 66);
    run_cycles(1, 200, 3, 200, 0);
    wait_done(1);

    expect_verdict(1, 1'b0, 2'd3, 200, 0);
    restart(1);
    run_cycles(1, 200, 0, 0, 0);
    wait_done(1);

    @(negedge clk);
    chk("scoreboard_empty", q0.size() + q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
